// File: rtl/nhr_pkg.sv
// Shared types and constants for the next-hop route controller.
// The flit type sits in the top two bits. Destination fields sit directly below it.
package nhr_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_FWD  = 2'b10
  } route_state_e;

  // NHR_IDLE equals the next-hop register's empty load value.
  localparam logic [2:0] PORT_N        = 3'b000;
  localparam logic [2:0] PORT_E        = 3'b001;
  localparam logic [2:0] PORT_S        = 3'b010;
  localparam logic [2:0] PORT_NHR_IDLE = 3'b011;
  localparam logic [2:0] PORT_W        = 3'b100;
  localparam logic [2:0] PORT_LOCAL    = 3'b101;

  // Offsets are counted down from the flit MSB.
  localparam int TYPE_W   = 2;
  localparam int DEST_OFS = 3;

endpackage

// File: rtl/xy_route_calc.sv
// Combinational XY (X-first) route function.
// It maps a destination coordinate to an output port code.
module xy_route_calc
  import nhr_pkg::*;
#(
  parameter int COORD_W = 2,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  output logic [2:0]         port
);

  localparam logic [COORD_W-1:0] X_HERE = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] Y_HERE = COORD_W'(MY_Y);

  always_comb begin
    port = PORT_LOCAL;
    if (dest_x > X_HERE)      port = PORT_E;
    else if (dest_x < X_HERE) port = PORT_W;
    else if (dest_y > Y_HERE) port = PORT_N;
    else if (dest_y < Y_HERE) port = PORT_S;
  end

endmodule

// File: rtl/nhr_route_ctrl.sv
// Route computation and packet tracking for one input buffer, feeding the next-hop register.
// Handshake: a flit moves when ib_read_o=1. In FWD that requires req_o (buffer non-empty) and grant_i in the same cycle.
module nhr_route_ctrl
  import nhr_pkg::*;
#(
  parameter int FLIT_W    = 32,
  parameter int COORD_W   = 2,
  parameter int MY_X      = 0,
  parameter int MY_Y      = 0,
  parameter int MAX_FLITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ib_empty_i,
  input  logic [FLIT_W-1:0] ib_flit_i,
  output logic              ib_read_o,
  input  logic              grant_i,
  output logic              req_o,
  output logic [2:0]        nhr_address_o,
  output logic              nhr_write_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FLITS - 1);

  route_state_e       state;
  logic [CNT_W-1:0]   flit_cnt;
  flit_type_e         front_type;
  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;
  logic [2:0]         route_port;
  logic               front_start;
  logic               idle_ready;
  logic               orphan_drop;
  logic               fwd_pop;
  logic               end_type;
  logic               pop_err;
  logic               pop_end;
  logic               unused_payload;

  assign front_type     = flit_type_e'(ib_flit_i[FLIT_W-1 -: TYPE_W]);
  assign dest_x         = ib_flit_i[FLIT_W-DEST_OFS -: COORD_W];
  assign dest_y         = ib_flit_i[FLIT_W-DEST_OFS-COORD_W -: COORD_W];
  assign unused_payload = ^ib_flit_i[FLIT_W-DEST_OFS-2*COORD_W:0];

  xy_route_calc #(
    .COORD_W (COORD_W),
    .MY_X    (MY_X),
    .MY_Y    (MY_Y)
  ) u_route (
    .dest_x (dest_x),
    .dest_y (dest_y),
    .port   (route_port)
  );

  // IDLE holds off for the cycle of the NHR_IDLE write, so back-to-back packets keep a 3-cycle gap.
  // Qualifying with reset keeps the drop path quiet while reset is held.
  always_comb begin
    front_start = !ib_empty_i && (front_type == FT_HEAD || front_type == FT_SINGLE);
    idle_ready  = (state == ST_IDLE) && !nhr_write_o && reset;
    orphan_drop = idle_ready && !ib_empty_i && !front_start;
    fwd_pop     = (state == ST_FWD) && grant_i && !ib_empty_i;
    end_type    = (front_type == FT_TAIL) || (front_type == FT_SINGLE);
    pop_err     = fwd_pop && (((front_type == FT_HEAD) && (flit_cnt != '0 || flit_cnt == CNT_LAST))
                              || ((flit_cnt == CNT_LAST) && !end_type));
    pop_end     = fwd_pop && (end_type || pop_err);
  end

  assign ib_read_o   = orphan_drop || fwd_pop;
  assign err_o       = orphan_drop || pop_err;
  assign req_o       = (state == ST_FWD) && !ib_empty_i;
  assign busy_o      = (state != ST_IDLE);
  assign dbg_state_o = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      flit_cnt      <= '0;
      nhr_address_o <= PORT_NHR_IDLE;
      nhr_write_o   <= 1'b0;
    end else begin
      nhr_write_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idle_ready && front_start) begin
            nhr_address_o <= route_port;
            nhr_write_o   <= 1'b1;
            state         <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          flit_cnt <= '0;
          state    <= ST_FWD;
        end
        ST_FWD: begin
          if (pop_end) begin
            nhr_address_o <= PORT_NHR_IDLE;
            nhr_write_o   <= 1'b1;
            state         <= ST_IDLE;
          end else if (fwd_pop) begin
            flit_cnt <= flit_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
